tmds_video_timing_ctrl: RTL
===========================

// Module: tmds_video_timing_ctrl
// PURPOSE
//  Sequences three TMDS_encoder channels (B, G, R) for a DVI link. Generates raster timing
//  (active/front-porch/sync/back-porch per axis), requests pixels from a source, and drives
//  D, DE, C0, C1 of each encoder. Sits between the frame/pixel source and the encoders.
//  Blue carries C0=HSYNC, C1=VSYNC; green and red carry C0=C1=0.
// PARAMETERS
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch, clocks
//  H_SYNC    96   HSYNC width, clocks
//  H_BP      48   horizontal back porch, clocks
//  V_ACTIVE  480  visible lines per frame
//  V_FP      10   vertical front porch, lines
//  V_SYNC    2    VSYNC width, lines
//  V_BP      33   vertical back porch, lines
//  HS_POL    0    HSYNC active level (0 = active-low)
//  VS_POL    0    VSYNC active level
// PORTS
//  clk          in   1   pixel clock; also clocks the encoders
//  rst          in   1   asynchronous, active-high reset
//  en           in   1   run enable; low = blank, counters held at 0
//  pix_rgb      in   24  {R,G,B} from source, valid 1 cycle after pix_req
//  pix_req      out  1   pixel request for coordinate pix_x/pix_y
//  pix_x        out  CLOG2(H_ACTIVE)  requested column
//  pix_y        out  CLOG2(V_ACTIVE)  requested row
//  frame_start  out  1   1-cycle pulse with request of pixel (0,0)
//  enc_de       out  1   DE to all three encoders
//  enc_d_r/g/b  out  8   D to the red/green/blue encoders
//  enc_c0_b     out  1   HSYNC into blue C0
//  enc_c1_b     out  1   VSYNC into blue C1
//  enc_c_rg     out  2   {C1,C0} for red/green; constant 2'b00
// BEHAVIOUR
//  - Reset (async): h_cnt=v_cnt=0; pix_req=0, pix_x=pix_y=0, frame_start=0, enc_de=0,
//    enc_d_*=0, enc_c0_b=~HS_POL, enc_c1_b=~VS_POL, enc_c_rg=0.
//  - H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. h_cnt 0..H_TOTAL-1; wraps to 0
//    at H_TOTAL-1 and increments v_cnt; v_cnt wraps to 0 at V_TOTAL-1 on that same edge.
//  - Per-axis phase FSM: ACTIVE -> FP -> SYNC -> BP -> ACTIVE, decoded from the counter:
//    ACTIVE [0,ACT), FP [ACT,ACT+FP), SYNC [ACT+FP,ACT+FP+SYNC), BP rest.
//  - Stage 1 (registered from counters, 1 clk after counter state): pix_req=H&V ACTIVE,
//    pix_x=h_cnt, pix_y=v_cnt, frame_start=(h_cnt==0 && v_cnt==0); syncs/DE piped.
//  - Stage 2 (1 clk after stage 1): enc_de=pix_req delayed; enc_d_*=pix_rgb when DE else 0;
//    enc_c0_b=HS_POL when H phase SYNC else ~HS_POL; enc_c1_b same with V/VS_POL.
//    Sync, DE and data leave aligned: 2-cycle latency from counter state to encoder inputs.
//  - pix_x/pix_y hold last value when pix_req=0 (don't care to consumer).
//  - VSYNC transitions coincide with the HSYNC-independent line boundary (h_cnt wrap).
//  - en low: next edge clears counters and pipeline as reset (syncs inactive, DE=0);
//    en rising restarts at (0,0) with frame_start. Mid-frame disable is allowed.
//  - Zero-width porches are legal (phase skipped); zero ACTIVE or SYNC is illegal.
//  - rst asserted mid-line: all outputs go to reset values immediately.
// STRUCTURE
//  - tmds_pkg: phase enum {PH_ACTIVE,PH_FP,PH_SYNC,PH_BP}; CLOG2 function; 640x480@60
//    default timing constants.
//  - Sub-module tmds_timing_axis: one counter plus phase decode, with a wrap-out and an
//    advance-in. Instantiated twice; the H wrap-out drives the V advance-in.
//  - Top holds the two pipeline stages and the sync polarity.
// TESTING (params H=4/1/2/1, V=3/1/1/1 -> 8x6 = 48-clk frame, HS_POL=VS_POL=0)
//  - Reset release, en=1: frame_start at clk 1; pix_req high clks 1-4 with x=0..3, y=0;
//    enc_de high clks 2-5.
//  - Data path: source returns pix_rgb={x,y,8'hA5} -> enc_d_b=A5 exactly when enc_de=1;
//    all enc_d_* are 0 when enc_de=0.
//  - Syncs: enc_c0_b low 2 clks per line at h_cnt 5-6 (+2 latency); enc_c1_b low for line 4
//    only (8 clks); enc_c_rg always 00.
//  - Wrap: after 48 clks a second frame_start; x and y return to 0; no DE in lines 3-5.
//  - en dropped at h_cnt=2 of line 1: next clk enc_de=0, syncs high; re-enable -> frame_start.
//  - Async rst pulse between edges mid-DE: outputs go to reset values before the next
//    edge; timing resumes at (0,0).

Source files
------------

// File: rtl/tmds_video_timing_ctrl_pkg.sv
// tmds_pkg: shared types and constants for the DVI raster timing controller.
//   phase_e  - per-axis raster phase (active, front porch, sync, back porch)
//   CLOG2    - ceil(log2(v)), never below 1, for sizing counters and coordinates
//   DEF_*    - 640x480@60 default timing
package tmds_pkg;

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FP     = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BP     = 2'd3
    } phase_e;

    function automatic int CLOG2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return (r < 1) ? 1 : r;
    endfunction

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

endpackage

// File: rtl/tmds_video_timing_ctrl_if.sv
// tmds_video_timing_ctrl_if: pixel-source and encoder-side signals of the timing controller.
//   master (controller): in en, pix_rgb; out pix_req, pix_x, pix_y, frame_start,
//                        enc_de, enc_d_r/g/b, enc_c0_b, enc_c1_b, enc_c_rg
//   slave  (source/encoders): the mirror image
interface tmds_video_timing_ctrl_if #(
    parameter int XW = 10,
    parameter int YW = 9
);
    logic          en;
    logic [23:0]   pix_rgb;
    logic          pix_req;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic          frame_start;
    logic          enc_de;
    logic [7:0]    enc_d_r;
    logic [7:0]    enc_d_g;
    logic [7:0]    enc_d_b;
    logic          enc_c0_b;
    logic          enc_c1_b;
    logic [1:0]    enc_c_rg;

    modport master (
        input  en, pix_rgb,
        output pix_req, pix_x, pix_y, frame_start,
               enc_de, enc_d_r, enc_d_g, enc_d_b, enc_c0_b, enc_c1_b, enc_c_rg
    );

    modport slave (
        output en, pix_rgb,
        input  pix_req, pix_x, pix_y, frame_start,
               enc_de, enc_d_r, enc_d_g, enc_d_b, enc_c0_b, enc_c1_b, enc_c_rg
    );
endinterface

// File: rtl/tmds_video_timing_ctrl_axis.sv
// tmds_timing_axis: one raster axis (horizontal or vertical).
//   clk, rst  pixel clock, async active-high reset
//   clr       synchronous clear to position 0 (controller disabled)
//   adv       advance one position this clock
//   cnt       current position 0..TOTAL-1
//   phase     phase of the current position, registered alongside cnt
//   wrap      advancing out of the last position this clock (feeds the next axis)
module tmds_timing_axis
    import tmds_pkg::*;
#(
    parameter int ACT  = DEF_H_ACTIVE,
    parameter int FP   = DEF_H_FP,
    parameter int SYNC = DEF_H_SYNC,
    parameter int BP   = DEF_H_BP,
    parameter int CW   = CLOG2(ACT + FP + SYNC + BP)
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          adv,
    output logic [CW-1:0] cnt,
    output phase_e        phase,
    output logic          wrap
);
    localparam int TOTAL = ACT + FP + SYNC + BP;

    logic [CW-1:0] cnt_nxt;
    logic [CW:0]   cx;
    phase_e        phase_nxt;

    // Phase is decoded from the next count so it is always in step with cnt.
    // One extra bit on the compare keeps ACT+FP+SYNC == TOTAL (no back porch)
    // from aliasing to zero; zero-width porches simply never match.
    always_comb begin
        wrap      = !clr && adv && (cnt == CW'(TOTAL - 1));
        cnt_nxt   = cnt;
        phase_nxt = phase;
        if (clr || wrap) cnt_nxt = '0;
        else if (adv)    cnt_nxt = cnt + 1'b1;
        cx = {1'b0, cnt_nxt};
        if      (cx < (CW+1)'(ACT))             phase_nxt = PH_ACTIVE;
        else if (cx < (CW+1)'(ACT + FP))        phase_nxt = PH_FP;
        else if (cx < (CW+1)'(ACT + FP + SYNC)) phase_nxt = PH_SYNC;
        else                                    phase_nxt = PH_BP;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            phase <= PH_ACTIVE;
        end else begin
            cnt   <= cnt_nxt;
            phase <= phase_nxt;
        end
    end
endmodule

// File: rtl/tmds_video_timing_ctrl.sv
// tmds_video_timing_ctrl: raster timing and pixel sequencing for three TMDS encoders.
//   clk, rst  pixel clock, async active-high reset
//   bus       master side: en/pix_rgb in; pixel request (pix_req, pix_x, pix_y,
//             frame_start) and encoder inputs (enc_de, enc_d_r/g/b, enc_c0_b=HSYNC,
//             enc_c1_b=VSYNC, enc_c_rg=00) out
// Stage 1 turns counter state into a pixel request; stage 2 latches the returned
// pixel together with delayed DE and syncs, so all encoder inputs stay aligned.
module tmds_video_timing_ctrl
    import tmds_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
)(
    input  logic                     clk,
    input  logic                     rst,
    tmds_video_timing_ctrl_if.master bus
);
    localparam int XW = CLOG2(H_ACTIVE);
    localparam int YW = CLOG2(V_ACTIVE);
    localparam int HW = CLOG2(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int VW = CLOG2(V_ACTIVE + V_FP + V_SYNC + V_BP);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    phase_e        h_ph, v_ph;
    logic          h_wrap, v_wrap_unused;

    tmds_timing_axis #(.ACT(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CW(HW)) u_h (
        .clk(clk), .rst(rst), .clr(!bus.en), .adv(1'b1),
        .cnt(h_cnt), .phase(h_ph), .wrap(h_wrap)
    );

    tmds_timing_axis #(.ACT(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CW(VW)) u_v (
        .clk(clk), .rst(rst), .clr(!bus.en), .adv(h_wrap),
        .cnt(v_cnt), .phase(v_ph), .wrap(v_wrap_unused)
    );

    // stage 1
    logic          s1_req, s1_fs, s1_hs, s1_vs;
    logic [XW-1:0] s1_x;
    logic [YW-1:0] s1_y;
    // stage 2
    logic          s2_de, s2_c0, s2_c1;
    logic [23:0]   s2_rgb;

    logic act;
    assign act = (h_ph == PH_ACTIVE) && (v_ph == PH_ACTIVE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst || !bus.en) begin
            s1_req <= 1'b0;
            s1_fs  <= 1'b0;
            s1_hs  <= 1'b0;
            s1_vs  <= 1'b0;
            s1_x   <= '0;
            s1_y   <= '0;
        end else begin
            s1_req <= act;
            s1_fs  <= (h_cnt == '0) && (v_cnt == '0);
            s1_hs  <= (h_ph == PH_SYNC);
            s1_vs  <= (v_ph == PH_SYNC);
            // Coordinates only move with a request; they hold otherwise.
            if (act) begin
                s1_x <= h_cnt[XW-1:0];
                s1_y <= v_cnt[YW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || !bus.en) begin
            s2_de  <= 1'b0;
            s2_rgb <= '0;
            s2_c0  <= ~HS_POL;
            s2_c1  <= ~VS_POL;
        end else begin
            s2_de  <= s1_req;
            s2_rgb <= s1_req ? bus.pix_rgb : 24'd0;
            s2_c0  <= s1_hs ? HS_POL : ~HS_POL;
            s2_c1  <= s1_vs ? VS_POL : ~VS_POL;
        end
    end

    assign bus.pix_req     = s1_req;
    assign bus.pix_x       = s1_x;
    assign bus.pix_y       = s1_y;
    assign bus.frame_start = s1_fs;
    assign bus.enc_de      = s2_de;
    assign bus.enc_d_r     = s2_rgb[23:16];
    assign bus.enc_d_g     = s2_rgb[15:8];
    assign bus.enc_d_b     = s2_rgb[7:0];
    assign bus.enc_c0_b    = s2_c0;
    assign bus.enc_c1_b    = s2_c1;
    assign bus.enc_c_rg    = 2'b00;
endmodule
